// File: rtl/mem_access_unit.sv
// RV32I memory-access stage: req/ack data bus, byte-lane steering, sign/zero extension,
// bus timeout and misalignment handling. Define MEM_MISALIGN_SPLIT_EN to split word-crossing accesses.
module mem_access_unit #(
    parameter int ADDR_W  = 17,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_reg_data,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              stall_req_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int         CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ1, REQ2} state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              split_q, split_d;
    logic [3:0]        sel2_q, sel2_d;
    logic [31:0]       hold_q, hold_d;

    logic        is_load, is_store, f3_ok, misal_raw, misal, do_split;
    logic [1:0]  a_lo;
    logic [3:0]  mask;
    logic [7:0]  sel8;
    logic [31:0] st_base, st_rot;
    logic [63:0] st_dbl, ld_src;
    logic [31:0] ld_sh, ld_ext;
    logic        unused_hi;

    assign unused_hi = ^mem_addr[31:ADDR_W];
    assign a_lo      = mem_addr[1:0];

    // Access decode and lane steering; store data is a rotate so aligned and split cases share one path.
    always_comb begin
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        mask     = 4'b0000;
        st_base  = mem_reg_data;
        unique case (funct3[1:0])
            2'b00:   begin mask = 4'b0001; st_base = {4{mem_reg_data[7:0]}};  end
            2'b01:   begin mask = 4'b0011; st_base = {2{mem_reg_data[15:0]}}; end
            2'b10:   begin mask = 4'b1111; st_base = mem_reg_data;            end
            default: begin mask = 4'b0000; st_base = mem_reg_data;            end
        endcase
        if (is_load)
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        else
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        misal_raw = ((funct3[1:0] == 2'b01) && a_lo[0]) ||
                    ((funct3[1:0] == 2'b10) && (a_lo != 2'b00));
        sel8   = {4'b0000, mask} << a_lo;
        st_dbl = {st_base, st_base} << {a_lo, 3'b000};
        st_rot = st_dbl[63:32];
`ifdef MEM_MISALIGN_SPLIT_EN
        misal    = 1'b0;
        do_split = misal_raw && (sel8[7:4] != 4'b0000);
`else
        misal    = misal_raw;
        do_split = 1'b0;
`endif
    end

    // Load path: REQ2 merges the held first word so the same shift handles split loads.
    always_comb begin
        ld_src = (state_q == REQ2) ? {mem_rdata_i, hold_q} : {mem_rdata_i, mem_rdata_i};
        ld_sh  = 32'(ld_src >> {a_lo, 3'b000});
        unique case (funct3)
            3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b100:  ld_ext = {24'h0, ld_sh[7:0]};
            3'b101:  ld_ext = {16'h0, ld_sh[15:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wdat_d      = wdat_q;
        cnt_d       = cnt_q;
        split_d     = split_q;
        sel2_d      = sel2_q;
        hold_d      = hold_q;
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_load || is_store) begin
                    wreg_o = 1'b0;
                    if (f3_ok && misal) begin
                        misalign_o = 1'b1;
                    end else if (f3_ok) begin
                        stall_req_o = 1'b1;
                        req_d       = 1'b1;
                        we_d        = is_store;
                        addr_d      = {mem_addr[ADDR_W-1:2], 2'b00};
                        sel_d       = sel8[3:0];
                        sel2_d      = sel8[7:4];
                        wdat_d      = st_rot;
                        split_d     = do_split;
                        cnt_d       = '0;
                        state_d     = REQ1;
                    end
                end
            end
            REQ1, REQ2: begin
                stall_req_o = 1'b1;
                wreg_o      = 1'b0;
                if (mem_ack_i) begin
                    if (state_q == REQ1 && split_q) begin
                        hold_d  = mem_rdata_i;
                        addr_d  = addr_q + ADDR_W'(4);
                        sel_d   = sel2_q;
                        cnt_d   = '0;
                        state_d = REQ2;
                    end else begin
                        stall_req_o = 1'b0;
                        wreg_o      = wreg_i;
                        wdata_o     = is_load ? ld_ext : wdata_i;
                        req_d       = 1'b0;
                        state_d     = IDLE;
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT)) begin
                    stall_req_o = 1'b0;
                    bus_err_o   = 1'b1;
                    req_d       = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            wd_o        = '0;
            wreg_o      = 1'b0;
            wdata_o     = '0;
            stall_req_o = 1'b0;
            misalign_o  = 1'b0;
            bus_err_o   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdat_q  <= '0;
            cnt_q   <= '0;
            split_q <= 1'b0;
            sel2_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            cnt_q   <= cnt_d;
            split_q <= split_d;
            sel2_q  <= sel2_d;
            hold_q  <= hold_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_sel_o   = sel_q;
    assign mem_wdata_o = wdat_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (ADDR_W=17, TIMEOUT=4); split-access case under MEM_MISALIGN_SPLIT_EN.
module tb_mem_access_unit;
    localparam int         ADDR_W   = 17;
    localparam int         TIMEOUT  = 4;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic              clk = 1'b0;
    logic              rst;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [31:0]       mem_addr, mem_reg_data, wdata_i, wdata_o, mem_wdata_o, mem_rdata_i;
    logic [4:0]        wd_i, wd_o;
    logic              wreg_i, wreg_o, stall_req_o, misalign_o, bus_err_o;
    logic              mem_req_o, mem_we_o, mem_ack_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_sel_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .mem_addr(mem_addr),
        .mem_reg_data(mem_reg_data), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req_o(stall_req_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        opcode    = OP_ALU;
        funct3    = 3'b000;
        mem_ack_i = 1'b0;
    endtask

    // One load/store: issue, `waits` cycles without ack, then ack.
    task automatic access(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rd, input logic [31:0] rdat,
                          input int waits, input logic [3:0] e_sel, input logic [31:0] e_addr,
                          input logic [31:0] e_wdat, input logic [31:0] e_out);
        int stalls;
        stalls       = 0;
        opcode       = st ? OP_STORE : OP_LOAD;
        funct3       = f3;
        mem_addr     = a;
        mem_reg_data = rd;
        wd_i         = 5'd9;
        wreg_i       = !st;
        wdata_i      = a;
        mem_ack_i    = 1'b0;
        #1;
        chk({tag, " issue stall"}, 32'(stall_req_o), 1);
        if (stall_req_o) stalls++;
        for (int w = 0; w <= waits; w++) begin
            cyc();
            mem_ack_i   = (w == waits);
            mem_rdata_i = rdat;
            #1;
            chk({tag, " req"}, 32'(mem_req_o), 1);
            chk({tag, " we"}, 32'(mem_we_o), 32'(st));
            chk({tag, " addr"}, 32'(mem_addr_o), e_addr);
            chk({tag, " sel"}, 32'(mem_sel_o), 32'(e_sel));
            if (st) chk({tag, " bus wdata"}, mem_wdata_o, e_wdat);
            if (stall_req_o) stalls++;
        end
        chk({tag, " wdata_o"}, wdata_o, e_out);
        chk({tag, " wreg_o"}, 32'(wreg_o), st ? 32'd0 : 32'd1);
        chk({tag, " wd_o"}, 32'(wd_o), 9);
        chk({tag, " stall cycles"}, stalls, 1 + waits);
        cyc();
        nop();
        #1;
        chk({tag, " req drop"}, 32'(mem_req_o), 0);
    endtask

    initial begin
        rst = 1'b1;
        nop();
        mem_addr     = 32'h0;
        mem_reg_data = 32'h0;
        mem_rdata_i  = 32'h0;
        wd_i         = 5'd5;
        wreg_i       = 1'b1;
        wdata_i      = 32'hDEAD_BEEF;
        cyc();
        cyc();
        #1;
        chk("rst stall", 32'(stall_req_o), 0);
        chk("rst wreg", 32'(wreg_o), 0);
        chk("rst wd", 32'(wd_o), 0);
        chk("rst wdata", wdata_o, 0);
        chk("rst req", 32'(mem_req_o), 0);
        chk("rst addr", 32'(mem_addr_o), 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("pass wd", 32'(wd_o), 5);
        chk("pass wreg", 32'(wreg_o), 1);
        chk("pass wdata", wdata_o, 32'hDEAD_BEEF);
        chk("pass stall", 32'(stall_req_o), 0);
        cyc();
        chk("pass no req", 32'(mem_req_o), 0);

        access("LB",  1'b0, 3'b000, 32'h103, 32'h0, 32'h8011_2233, 0, 4'b1000, 32'h100, 32'h0, 32'hFFFF_FF80);
        access("LBU", 1'b0, 3'b100, 32'h101, 32'h0, 32'h8011_2233, 0, 4'b0010, 32'h100, 32'h0, 32'h0000_0022);
        access("LH",  1'b0, 3'b001, 32'h102, 32'h0, 32'h8011_2233, 0, 4'b1100, 32'h100, 32'h0, 32'hFFFF_8011);
        access("LHU", 1'b0, 3'b101, 32'h100, 32'h0, 32'h8011_2233, 0, 4'b0011, 32'h100, 32'h0, 32'h0000_2233);
        access("LW",  1'b0, 3'b010, 32'h104, 32'h0, 32'h8011_2233, 1, 4'b1111, 32'h104, 32'h0, 32'h8011_2233);
        access("LWhi",1'b0, 3'b010, 32'h2_0104, 32'h0, 32'h0BAD_F00D, 0, 4'b1111, 32'h104, 32'h0, 32'h0BAD_F00D);
        access("SH",  1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 32'h0, 3, 4'b1100, 32'h20, 32'hABCD_ABCD, 32'h22);
        access("SB",  1'b1, 3'b000, 32'h21, 32'h1234_565A, 32'h0, 0, 4'b0010, 32'h20, 32'h5A5A_5A5A, 32'h21);
        access("SW",  1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 32'h0, 2, 4'b1111, 32'h30, 32'hCAFE_F00D, 32'h30);

        // Timeout: 4 waiting cycles, then the abort cycle.
        opcode = OP_LOAD; funct3 = 3'b010; mem_addr = 32'h40; wreg_i = 1'b1; mem_ack_i = 1'b0;
        #1;
        chk("to issue stall", 32'(stall_req_o), 1);
        for (int w = 0; w < TIMEOUT; w++) begin
            cyc();
            chk("to wait stall", 32'(stall_req_o), 1);
            chk("to wait berr", 32'(bus_err_o), 0);
        end
        cyc();
        chk("to berr", 32'(bus_err_o), 1);
        chk("to stall", 32'(stall_req_o), 0);
        chk("to wreg", 32'(wreg_o), 0);
        cyc();
        nop();
        #1;
        chk("to req drop", 32'(mem_req_o), 0);
        chk("to berr pulse", 32'(bus_err_o), 0);

`ifdef MEM_MISALIGN_SPLIT_EN
        opcode = OP_LOAD; funct3 = 3'b010; mem_addr = 32'h102; wreg_i = 1'b1; mem_ack_i = 1'b0;
        #1;
        chk("split no misalign", 32'(misalign_o), 0);
        chk("split issue stall", 32'(stall_req_o), 1);
        cyc();
        mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAA_1111;
        #1;
        chk("split r1 addr", 32'(mem_addr_o), 32'h100);
        chk("split r1 sel", 32'(mem_sel_o), 32'hC);
        chk("split r1 stall", 32'(stall_req_o), 1);
        cyc();
        mem_rdata_i = 32'h2222_BBBB;
        #1;
        chk("split r2 addr", 32'(mem_addr_o), 32'h104);
        chk("split r2 sel", 32'(mem_sel_o), 32'h3);
        chk("split r2 stall", 32'(stall_req_o), 0);
        chk("split data", wdata_o, 32'hBBBB_AAAA);
        cyc();
        nop();
        #1;
        chk("split req drop", 32'(mem_req_o), 0);
`else
        opcode = OP_LOAD; funct3 = 3'b010; mem_addr = 32'h101; wreg_i = 1'b1;
        #1;
        chk("mis LW flag", 32'(misalign_o), 1);
        chk("mis LW stall", 32'(stall_req_o), 0);
        chk("mis LW wreg", 32'(wreg_o), 0);
        cyc();
        chk("mis LW no req", 32'(mem_req_o), 0);
        opcode = OP_STORE; funct3 = 3'b001; mem_addr = 32'h23;
        #1;
        chk("mis SH flag", 32'(misalign_o), 1);
        cyc();
        chk("mis SH no req", 32'(mem_req_o), 0);
        nop();
        #1;
        chk("mis flag clear", 32'(misalign_o), 0);
`endif

        opcode = OP_LOAD; funct3 = 3'b011; mem_addr = 32'h100; wreg_i = 1'b1;
        #1;
        chk("bad f3 stall", 32'(stall_req_o), 0);
        chk("bad f3 wreg", 32'(wreg_o), 0);
        cyc();
        chk("bad f3 no req", 32'(mem_req_o), 0);

        // Reset in the second wait cycle; a late ack must be ignored.
        opcode = OP_LOAD; funct3 = 3'b010; mem_addr = 32'h50; wreg_i = 1'b1; mem_ack_i = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("mid rst stall", 32'(stall_req_o), 0);
        cyc();
        rst = 1'b0;
        opcode = OP_ALU; wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        #1;
        chk("post rst req", 32'(mem_req_o), 0);
        chk("post rst sel", 32'(mem_sel_o), 0);
        chk("post rst addr", 32'(mem_addr_o), 0);
        chk("post rst stall", 32'(stall_req_o), 0);
        chk("post rst wreg", 32'(wreg_o), 0);
        chk("post rst wdata", wdata_o, 0);
        chk("post rst berr", 32'(bus_err_o), 0);
        cyc();
        mem_ack_i = 1'b0;
        #1;
        chk("late ack no req", 32'(mem_req_o), 0);
        access("LW post-rst", 1'b0, 3'b010, 32'h60, 32'h0, 32'h5555_AAAA, 0, 4'b1111, 32'h60, 32'h0, 32'h5555_AAAA);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
